// File: rtl/periph_rx_bridge_if.sv
// Peripheral-to-CPU receive bridge bus: send/ack handshake in, valid/ready out.
// No logic; pure signal bundle, latency is defined by the bridge itself.
// Backpressure: ack withheld while full; out_ready throttles the CPU side.
interface periph_rx_bridge_if #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // peripheral side
  logic              send;
  logic [DATA_W-1:0] newData;
  logic              ack;
  // cpu side
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  count;
  logic              full;

  // bridge (responder) view
  modport slave (
    input  send, newData, out_ready,
    output ack, out_data, out_valid, count, full
  );

  // driver view (peripheral + cpu stimulus)
  modport master (
    output send, newData, out_ready,
    input  ack, out_data, out_valid, count, full
  );
endinterface

// File: rtl/periph_rx_bridge.sv
// Captures peripheral words via four-phase send/ack into a FWFT FIFO read by valid/ready.
// Latency: send edge to ack edge SYNC_STAGES+1 clks; word visible the cycle after capture.
// Backpressure: a full FIFO holds ack low so the peripheral stalls; nothing is dropped.
module periph_rx_bridge #(
  parameter int DATA_W      = 4,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  periph_rx_bridge_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, WAIT_LOW} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   send_s;
  state_t                 state;
  logic                   ack_q;
  logic [DATA_W-1:0]      mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count_q;
  logic                   full_w;
  logic                   valid_w;
  logic                   push;
  logic                   pop;

  assign send_s  = sync_q[SYNC_STAGES-1];
  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign valid_w = (count_q != '0);
  // full is this cycle's value: a same-cycle pop never frees room for a push
  assign push    = (state == IDLE) && send_s && !full_w;
  assign pop     = valid_w && bus.out_ready;

  // send is foreign-clocked; only this chain ever looks at the raw input
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.send};
  end

  // handshake FSM: one capture per send pulse, ack registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ack_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (push) begin
            ack_q <= 1'b1;
            state <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!send_s) begin
            ack_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          ack_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // storage: newData is stable while send is high, so it is safe to sample here
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.newData;
  end

  // pointers wrap naturally (DEPTH is a power of two); count tracked explicitly
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.out_data  = mem[rd_ptr];
  assign bus.out_valid = valid_w;
  assign bus.count     = count_q;
  assign bus.full      = full_w;
endmodule

// File: tb/tb_periph_rx_bridge.sv
// Directed bench for periph_rx_bridge at DATA_W=4, DEPTH=4, SYNC_STAGES=2.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Every handshake wait is bounded so a stuck DUT still reaches the summary.
module tb_periph_rx_bridge;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  periph_rx_bridge_if #(.DATA_W(4), .DEPTH(4)) bus ();

  periph_rx_bridge #(.DATA_W(4), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // full four-phase handshake; returns head word and count seen when ack rises
  task automatic hs(input logic [3:0] d, output logic [3:0] got, output logic [2:0] cnt);
    int n;
    bus.newData = d;
    bus.send    = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus.ack !== 1'b1 && n < 20);
    chk("hs_ack_rise", 32'(bus.ack), 1);
    got = bus.out_data;
    cnt = bus.count;
    bus.send = 1'b0;
    n = 0;
    do begin tick(); n++; end while (bus.ack !== 1'b0 && n < 20);
    chk("hs_ack_fall", 32'(bus.ack), 0);
  endtask

  initial begin
    logic [3:0] got;
    logic [2:0] cnt;
    n_tests = 0;
    n_fail  = 0;
    rst           = 1'b1;
    bus.send      = 1'b0;
    bus.newData   = 4'h0;
    bus.out_ready = 1'b0;

    // reset
    tick(); tick(); tick();
    chk("rst_ack",   32'(bus.ack), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_full",  32'(bus.full), 0);
    chk("rst_count", 32'(bus.count), 0);
    rst = 1'b0;

    // single transfer with exact latency
    bus.newData = 4'hA;
    bus.send    = 1'b1;
    tick(); tick();
    chk("single_ack_early", 32'(bus.ack), 0);
    tick();
    chk("single_ack",   32'(bus.ack), 1);
    chk("single_valid", 32'(bus.out_valid), 1);
    chk("single_data",  32'(bus.out_data), 32'hA);
    chk("single_count", 32'(bus.count), 1);
    bus.send = 1'b0;
    tick(); tick();
    chk("single_ack_hold", 32'(bus.ack), 1);
    tick();
    chk("single_ack_fall", 32'(bus.ack), 0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("single_drained", 32'(bus.count), 0);
    chk("single_valid0",  32'(bus.out_valid), 0);

    // back-pressure
    for (int i = 1; i <= 4; i++) hs(4'(i), got, cnt);
    chk("bp_full",  32'(bus.full), 1);
    chk("bp_count", 32'(bus.count), 4);
    bus.newData = 4'h5;
    bus.send    = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("bp_ack_held", 32'(bus.ack), 0);
    chk("bp_count4",   32'(bus.count), 4);
    chk("bp_head",     32'(bus.out_data), 32'h1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_pop_count", 32'(bus.count), 3);
    chk("bp_pop_ack",   32'(bus.ack), 0);
    chk("bp_pop_head",  32'(bus.out_data), 32'h2);
    tick();
    chk("bp_cap_ack",   32'(bus.ack), 1);
    chk("bp_cap_count", 32'(bus.count), 4);
    bus.send = 1'b0;
    tick(); tick(); tick();
    chk("bp_ack_fall", 32'(bus.ack), 0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain", 32'(bus.out_data), 32'(i + 2));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    chk("bp_empty", 32'(bus.count), 0);

    // ordering across two pointer wraps
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      hs(4'(i), got, cnt);
      chk("ord_data",  32'(got), 32'(i));
      chk("ord_count", 32'(cnt), 1);
    end
    tick();
    bus.out_ready = 1'b0;
    chk("ord_empty", 32'(bus.count), 0);

    // long send hold: exactly one write
    bus.newData = 4'h7;
    bus.send    = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("hold_count", 32'(bus.count), 1);
    chk("hold_ack",   32'(bus.ack), 1);
    bus.send = 1'b0;
    tick(); tick();
    chk("hold_ack_late", 32'(bus.ack), 1);
    tick();
    chk("hold_ack_fall", 32'(bus.ack), 0);
    chk("hold_count1",   32'(bus.count), 1);
    chk("hold_data",     32'(bus.out_data), 32'h7);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // simultaneous push and pop
    hs(4'h8, got, cnt);
    hs(4'h9, got, cnt);
    chk("sim_pre_count", 32'(bus.count), 2);
    bus.newData = 4'hC;
    bus.send    = 1'b1;
    tick(); tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("sim_ack",   32'(bus.ack), 1);
    chk("sim_count", 32'(bus.count), 2);
    chk("sim_head",  32'(bus.out_data), 32'h9);
    bus.send = 1'b0;
    tick(); tick(); tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("sim_next", 32'(bus.out_data), 32'hC);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("sim_empty", 32'(bus.count), 0);

    // reset in the middle of a handshake
    hs(4'h1, got, cnt);
    hs(4'h2, got, cnt);
    bus.newData = 4'h3;
    bus.send    = 1'b1;
    tick(); tick(); tick();
    chk("mid_ack",   32'(bus.ack), 1);
    chk("mid_count", 32'(bus.count), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_count", 32'(bus.count), 0);
    chk("mid_rst_ack",   32'(bus.ack), 0);
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    tick(); tick();
    chk("mid_ack_early", 32'(bus.ack), 0);
    tick();
    chk("mid_reack",  32'(bus.ack), 1);
    chk("mid_count1", 32'(bus.count), 1);
    chk("mid_data",   32'(bus.out_data), 32'h3);
    bus.send = 1'b0;
    tick(); tick(); tick();
    chk("mid_ack_fall", 32'(bus.ack), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/periph_rx_bridge.md
Name: periph_rx_bridge

Overview:
- Parametrised successor to the peripheral-to-CPU send/ack link.
- Receives words from a peripheral over a four-phase send/ack handshake and buffers them in a FIFO.
- Presents the words to the CPU side through a valid/ready interface.
- The send input may come from a foreign clock, so it is synchronised internally. newData is qualified by the protocol: it is stable while send is high.

Parameters:
- DATA_W, 4, width of newData and out_data.
- DEPTH, 4, number of FIFO entries; must be a power of 2 and ≥2.
- SYNC_STAGES, 2, flip-flop stages on send; must be ≥2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- send  in  1  peripheral request, four-phase; asynchronous to clk.
- newData  in  DATA_W  peripheral word; stable while send=1.
- ack  out  1  acknowledge to peripheral; registered.
- out_data  out  DATA_W  head-of-FIFO word, first-word-fall-through.
- out_valid  out  1  high when FIFO is non-empty.
- out_ready  in  1  CPU accepts the word when out_valid&&out_ready.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- full  out  1  count==DEPTH.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Sync chain, state, pointers and count go to 0.
  - ack=0, out_valid=0, full=0, count=0.
  - FIFO contents are don't-care. out_data is don't-care while out_valid=0.
- Synchroniser: send_s is the last stage of a SYNC_STAGES-flop chain clocked by clk. Nothing other than the chain reads raw send.
- FSM states: IDLE, WAIT_LOW. Reset state is IDLE.
  - IDLE, send_s=1 and full=0:
    - Write newData at mem[wr_ptr].
    - wr_ptr++ (wraps modulo DEPTH).
    - ack<=1, go to WAIT_LOW.
  - IDLE, send_s=1 and full=1: stay in IDLE, ack stays 0. This back-pressures the peripheral; no data is lost and no overflow is possible.
  - IDLE, send_s=0: stay.
  - WAIT_LOW, send_s=1: hold ack=1. No further write, so exactly one write per handshake.
  - WAIT_LOW, send_s=0: ack<=0, go to IDLE.
- Latency:
  - send rising edge to ack=1 is SYNC_STAGES+1 clk edges when not full.
  - Word visible on out_data (out_valid=1) in the cycle after the capture edge if the FIFO was empty.
  - send falling edge to ack=0 is SYNC_STAGES+1 edges.
- Pop: out_valid&&out_ready at an edge advances rd_ptr (wraps modulo DEPTH) and decrements count. out_ready is ignored while out_valid=0.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Push eligibility uses full from the current cycle. A pop in the same cycle does not make room for a push while full; that push happens next cycle.
- out_data = mem[rd_ptr] combinationally from registered state. It must stay stable while out_valid=1 and no pop occurs.
- Pointers are $clog2(DEPTH) bits with natural wrap. count is maintained explicitly and never exceeds DEPTH or goes below 0.
- Reset mid-handshake: ack drops immediately and state returns to IDLE. A send still high after reset release is treated as a new transfer and re-captured after the sync latency. This duplicate is accepted behaviour.

Test Plan:
- Single transfer, DEPTH=4:
  - rst high 3 cycles, then send=1 with newData=4'hA.
  - ack=1 exactly 3 edges later; out_valid=1 with out_data=4'hA next cycle; count=1.
  - Drop send → ack=0 3 edges later.
- Back-pressure:
  - out_ready=0, four handshakes 1,2,3,4 → full=1, count=4.
  - Fifth send=1 with 4'h5 → ack stays 0 indefinitely.
  - Pulse out_ready one cycle → 4'h1 pops; next cycle 4'h5 captured, ack=1, count=4.
- Ordering and wrap:
  - 10 handshakes 0..9 with out_ready=1 throughout.
  - out_data sequence is 0..9 in order; count never exceeds 1; pointers wrap twice.
- Long send hold: send held high 20 cycles → exactly one write; count=1; ack high until 3 edges after send falls.
- Simultaneous push/pop:
  - count=2, out_ready=1 on the same edge as a capture.
  - count stays 2; popped word is the oldest.
- Reset mid-operation:
  - count=3 and ack=1, assert rst 1 cycle with send still high.
  - count=0 and ack=0 after the edge; ack re-asserts 3 edges after release; count=1.
